// File: rtl/pong_match_ctrl.sv
// Match sequencer for the Pong datapath.
// Owns the two score registers, the serve / post-point pause timing and the
// ball release control, and time-multiplexes the 7-seg display as "A - - B".
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_CYCLES = 100_000_000,
  parameter int SCAN_DIV     = 100_000,
  parameter int CNT_W        = 27
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       start,
  input  logic       point_A,
  input  logic       point_B,
  output logic       ball_reset,
  output logic       ball_run,
  output logic [3:0] score_A,
  output logic [3:0] score_B,
  output logic [1:0] winner,
  output logic [2:0] state,
  output logic [3:0] an,
  output logic [3:0] digit_code
);

  // A one-clock scan divider still needs a 1-bit counter to stay legal.
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [3:0]        WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0]  PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE   = SCAN_W'(1);

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_RALLY     = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   pause_cnt;
  logic               start_prev;
  logic               point_a_prev;
  logic               point_b_prev;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;

  logic start_ev;
  logic point_a_ev;
  logic point_b_ev;
  logic [3:0] score_a_inc;
  logic [3:0] score_b_inc;

  // Rising-edge events: a held-high input only counts on its first cycle.
  assign start_ev   = start   & ~start_prev;
  assign point_a_ev = point_A & ~point_a_prev;
  assign point_b_ev = point_B & ~point_b_prev;

  assign score_a_inc = score_A + 4'd1;
  assign score_b_inc = score_B + 4'd1;

  // Ball control is a pure decode of the current state.
  assign ball_reset = (state_reg == S_IDLE) || (state_reg == S_SERVE) ||
                      (state_reg == S_GAME_OVER);
  assign ball_run   = (state_reg == S_RALLY);
  assign state      = state_reg;

  // Match FSM: edge history, pause timing, scores and winner.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      pause_cnt    <= '0;
      score_A      <= 4'd0;
      score_B      <= 4'd0;
      winner       <= 2'b00;
      start_prev   <= 1'b0;
      point_a_prev <= 1'b0;
      point_b_prev <= 1'b0;
    end else begin
      start_prev   <= start;
      point_a_prev <= point_A;
      point_b_prev <= point_B;
      case (state_reg)
        S_IDLE: begin
          if (start_ev) begin
            state_reg <= S_SERVE;
            pause_cnt <= '0;
          end
        end
        S_SERVE: begin
          if (pause_cnt == PAUSE_LAST) begin
            state_reg <= S_RALLY;
            pause_cnt <= '0;
          end else begin
            pause_cnt <= pause_cnt + CNT_ONE;
          end
        end
        S_RALLY: begin
          if (point_a_ev && point_b_ev) begin
            // Both sides claim the point: nobody scores, replay the serve.
            state_reg <= S_SERVE;
            pause_cnt <= '0;
          end else if (point_a_ev) begin
            score_A   <= score_a_inc;
            pause_cnt <= '0;
            if (score_a_inc == WIN_VAL) begin
              state_reg <= S_GAME_OVER;
              winner    <= 2'b01;
            end else begin
              state_reg <= S_POINT;
            end
          end else if (point_b_ev) begin
            score_B   <= score_b_inc;
            pause_cnt <= '0;
            if (score_b_inc == WIN_VAL) begin
              state_reg <= S_GAME_OVER;
              winner    <= 2'b10;
            end else begin
              state_reg <= S_POINT;
            end
          end
        end
        S_POINT: begin
          if (pause_cnt == PAUSE_LAST) begin
            state_reg <= S_SERVE;
            pause_cnt <= '0;
          end else begin
            pause_cnt <= pause_cnt + CNT_ONE;
          end
        end
        S_GAME_OVER: begin
          if (start_ev) begin
            score_A   <= 4'd0;
            score_B   <= 4'd0;
            winner    <= 2'b00;
            state_reg <= S_SERVE;
            pause_cnt <= '0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          pause_cnt <= '0;
        end
      endcase
    end
  end

  // Free-running digit scan: dwell SCAN_DIV clocks on each of the 4 digits.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_ONE;
    end
  end

  // Anode select and digit code for the current scan slot; loser blanks at game over.
  always_comb begin
    an         = 4'b1110;
    digit_code = CODE_DASH;
    case (digit_idx)
      2'd0: begin
        an         = 4'b1110;
        digit_code = (state_reg == S_GAME_OVER && winner == 2'b01) ? CODE_BLANK : score_B;
      end
      2'd1: begin
        an         = 4'b1101;
        digit_code = CODE_DASH;
      end
      2'd2: begin
        an         = 4'b1011;
        digit_code = CODE_DASH;
      end
      default: begin
        an         = 4'b0111;
        digit_code = (state_reg == S_GAME_OVER && winner == 2'b10) ? CODE_BLANK : score_A;
      end
    endcase
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl with a small match reference model.
module tb_pong_match_ctrl;

  localparam int WIN   = 3;
  localparam int PAUSE = 4;
  localparam int SCAN  = 2;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_RALLY = 2;
  localparam int P_POINT = 3;
  localparam int P_GO    = 4;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       point_A;
  logic       point_B;
  logic       ball_reset;
  logic       ball_run;
  logic [3:0] score_A;
  logic [3:0] score_B;
  logic [1:0] winner;
  logic [2:0] state;
  logic [3:0] an;
  logic [3:0] digit_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: match phase, cycles left in a pause, scores, scan time.
  int m_phase;
  int m_left;
  int m_sa;
  int m_sb;
  int m_win;
  int m_cycles;
  bit m_ps, m_pa, m_pb;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .PAUSE_CYCLES(PAUSE), .SCAN_DIV(SCAN), .CNT_W(3)
  ) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .start(start),
    .point_A(point_A), .point_B(point_B),
    .ball_reset(ball_reset), .ball_run(ball_run),
    .score_A(score_A), .score_B(score_B), .winner(winner),
    .state(state), .an(an), .digit_code(digit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    m_phase = P_IDLE; m_left = 0; m_sa = 0; m_sb = 0; m_win = 0;
    m_cycles = 0; m_ps = 0; m_pa = 0; m_pb = 0;
  endtask

  // One clock of the match rules as seen from the players' side.
  task automatic m_step(input bit s, input bit a, input bit b);
    bit se, ae, be;
    se = s && !m_ps; ae = a && !m_pa; be = b && !m_pb;
    m_ps = s; m_pa = a; m_pb = b;
    m_cycles++;
    case (m_phase)
      P_IDLE: if (se) begin m_phase = P_SERVE; m_left = PAUSE; end
      P_SERVE: begin m_left--; if (m_left == 0) m_phase = P_RALLY; end
      P_RALLY: begin
        if (ae && be) begin m_phase = P_SERVE; m_left = PAUSE; end
        else if (ae) begin
          m_sa++;
          if (m_sa == WIN) begin m_phase = P_GO; m_win = 1; end
          else begin m_phase = P_POINT; m_left = PAUSE; end
        end else if (be) begin
          m_sb++;
          if (m_sb == WIN) begin m_phase = P_GO; m_win = 2; end
          else begin m_phase = P_POINT; m_left = PAUSE; end
        end
      end
      P_POINT: begin m_left--; if (m_left == 0) begin m_phase = P_SERVE; m_left = PAUSE; end end
      default: if (se) begin m_sa = 0; m_sb = 0; m_win = 0; m_phase = P_SERVE; m_left = PAUSE; end
    endcase
  endtask

  function automatic logic [3:0] exp_an();
    int idx = (m_cycles / SCAN) % 4;
    logic [3:0] one = 4'b0001;
    return ~(one << idx);
  endfunction

  function automatic logic [3:0] exp_digit();
    int idx = (m_cycles / SCAN) % 4;
    if (idx == 0) return (m_phase == P_GO && m_win == 1) ? 4'hF : 4'(m_sb);
    if (idx == 3) return (m_phase == P_GO && m_win == 2) ? 4'hF : 4'(m_sa);
    return 4'hA;
  endfunction

  // Apply inputs for one clock, then advance the model with the same inputs.
  task automatic step(input bit s, input bit a, input bit b);
    start = s; point_A = a; point_B = b;
    @(posedge clk); #1;
    m_step(s, a, b);
    if (s || a || b)
      $display("[TB] txn start=%0b point_A=%0b point_B=%0b -> state=%0d A=%0d B=%0d win=%0d",
               s, a, b, state, score_A, score_B, winner);
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    m_reset();
  endtask

  // Idle the inputs until the serve finishes; bounded so a stuck DUT still ends.
  task automatic run_to_rally();
    int guard = 0;
    while (m_phase != P_RALLY && guard < 40) begin
      step(0, 0, 0);
      guard++;
    end
    n_tests++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL run_to_rally: state=%0d required 2 after %0d cycles", state, guard);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; point_A = 0; point_B = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests += 7;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    if (score_A !== 4'd0) begin n_fail++; $display("FAIL reset_score_A: got %0d want 0", score_A); end
    if (score_B !== 4'd0) begin n_fail++; $display("FAIL reset_score_B: got %0d want 0", score_B); end
    if (winner !== 2'b00) begin n_fail++; $display("FAIL reset_winner: got %0b want 00", winner); end
    if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b want 1110", an); end
    if (ball_reset !== 1'b1) begin n_fail++; $display("FAIL reset_ball_reset: got %b want 1", ball_reset); end
    if (ball_run !== 1'b0) begin n_fail++; $display("FAIL reset_ball_run: got %b want 0", ball_run); end
    release_reset();
  endtask

  task automatic test_serve();
    // Idle with no start stays idle.
    step(0, 0, 0);
    n_tests++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL idle_hold: got %0d want 0", state); end
    step(1, 0, 0);
    n_tests += 2;
    if (state !== 3'd1) begin n_fail++; $display("FAIL serve_enter: got %0d want 1", state); end
    if (ball_reset !== 1'b1) begin n_fail++; $display("FAIL serve_ball_reset: got %b want 1", ball_reset); end
    for (int i = 1; i <= 4; i++) begin
      step(i == 2, 0, 0);
      n_tests += 2;
      if (ball_run !== (i == 4)) begin
        n_fail++; $display("FAIL serve_dwell[%0d]: ball_run=%b want %b", i, ball_run, (i == 4));
      end
      if (state !== 3'(m_phase)) begin
        n_fail++; $display("FAIL serve_state[%0d]: got %0d want %0d", i, state, m_phase);
      end
    end
  endtask

  task automatic test_scoring();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      n_tests += 3;
      if (score_A !== 4'd1) begin n_fail++; $display("FAIL score_once[%0d]: got %0d want 1", i, score_A); end
      if (state !== 3'd3) begin n_fail++; $display("FAIL point_state[%0d]: got %0d want 3", i, state); end
      if (ball_run !== 1'b0 || ball_reset !== 1'b0) begin
        n_fail++; $display("FAIL point_frozen[%0d]: run=%b reset=%b want 0 0", i, ball_run, ball_reset);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, i == 0);
      n_tests += 2;
      if (score_B !== 4'd0) begin n_fail++; $display("FAIL point_B_ignored[%0d]: got %0d want 0", i, score_B); end
      if (state !== 3'(m_phase)) begin
        n_fail++; $display("FAIL point_seq[%0d]: got %0d want %0d", i, state, m_phase);
      end
    end
    n_tests++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL point_to_rally: got %0d want 2", state); end
  endtask

  task automatic test_simultaneous();
    step(0, 1, 1);
    n_tests += 3;
    if (score_A !== 4'd1) begin n_fail++; $display("FAIL simul_score_A: got %0d want 1", score_A); end
    if (score_B !== 4'd0) begin n_fail++; $display("FAIL simul_score_B: got %0d want 0", score_B); end
    if (state !== 3'd1) begin n_fail++; $display("FAIL simul_state: got %0d want 1", state); end
    step(0, 0, 0);
  endtask

  task automatic test_win();
    bit saw_blank = 0;
    bit saw_three = 0;
    run_to_rally();
    step(0, 1, 0);
    run_to_rally();
    step(0, 1, 0);
    n_tests += 4;
    if (state !== 3'd4) begin n_fail++; $display("FAIL win_state: got %0d want 4", state); end
    if (winner !== 2'b01) begin n_fail++; $display("FAIL win_winner: got %b want 01", winner); end
    if (score_A !== 4'd3) begin n_fail++; $display("FAIL win_score_A: got %0d want 3", score_A); end
    if (ball_reset !== 1'b1) begin n_fail++; $display("FAIL win_ball_reset: got %b want 1", ball_reset); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      if (an === 4'b1110 && digit_code === 4'hF) saw_blank = 1;
      if (an === 4'b0111 && digit_code === 4'h3) saw_three = 1;
      n_tests++;
      if (digit_code !== exp_digit()) begin
        n_fail++; $display("FAIL win_digit[%0d]: got %h want %h", i, digit_code, exp_digit());
      end
    end
    n_tests += 2;
    if (!saw_blank) begin n_fail++; $display("FAIL win_loser_blank: idx0 never showed F"); end
    if (!saw_three) begin n_fail++; $display("FAIL win_score_digit: idx3 never showed 3"); end
    step(1, 0, 0);
    n_tests += 4;
    if (score_A !== 4'd0 || score_B !== 4'd0) begin
      n_fail++; $display("FAIL restart_scores: got %0d %0d want 0 0", score_A, score_B);
    end
    if (winner !== 2'b00) begin n_fail++; $display("FAIL restart_winner: got %b want 00", winner); end
    if (state !== 3'd1) begin n_fail++; $display("FAIL restart_state: got %0d want 1", state); end
    if (digit_code !== exp_digit()) begin
      n_fail++; $display("FAIL restart_digit: got %h want %h", digit_code, exp_digit());
    end
  endtask

  task automatic test_scan();
    logic [3:0] codes [4];
    codes[0] = 4'h1; codes[1] = 4'hA; codes[2] = 4'hA; codes[3] = 4'h2;
    run_to_rally(); step(0, 1, 0);
    run_to_rally(); step(0, 1, 0);
    run_to_rally(); step(0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      int idx;
      step(0, 0, 0);
      idx = (m_cycles / SCAN) % 4;
      n_tests += 2;
      if (an !== exp_an()) begin n_fail++; $display("FAIL scan_an[%0d]: got %b want %b", i, an, exp_an()); end
      if (digit_code !== codes[idx]) begin
        n_fail++; $display("FAIL scan_digit[%0d]: got %h want %h", i, digit_code, codes[idx]);
      end
    end
  endtask

  task automatic test_reset_mid();
    run_to_rally();
    reset_n = 1'b0;
    #2;
    n_tests += 6;
    if (state !== 3'd0) begin n_fail++; $display("FAIL midreset_state: got %0d want 0", state); end
    if (score_A !== 4'd0 || score_B !== 4'd0) begin
      n_fail++; $display("FAIL midreset_scores: got %0d %0d want 0 0", score_A, score_B);
    end
    if (an !== 4'b1110) begin n_fail++; $display("FAIL midreset_an: got %b want 1110", an); end
    if (ball_reset !== 1'b1) begin n_fail++; $display("FAIL midreset_ball_reset: got %b want 1", ball_reset); end
    if (ball_run !== 1'b0) begin n_fail++; $display("FAIL midreset_ball_run: got %b want 0", ball_run); end
    @(posedge clk); #1;
    if (state !== 3'd0) begin n_fail++; $display("FAIL midreset_hold: got %0d want 0", state); end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit s, a, b;
      s = ($urandom % 12) == 0;
      a = ($urandom % 4) == 0;
      b = ($urandom % 4) == 0;
      step(s, a, b);
      n_tests += 7;
      if (state !== 3'(m_phase)) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state, m_phase); end
      if (score_A !== 4'(m_sa)) begin n_fail++; $display("FAIL rnd_score_A[%0d]: got %0d want %0d", i, score_A, m_sa); end
      if (score_B !== 4'(m_sb)) begin n_fail++; $display("FAIL rnd_score_B[%0d]: got %0d want %0d", i, score_B, m_sb); end
      if (winner !== 2'(m_win)) begin n_fail++; $display("FAIL rnd_winner[%0d]: got %0d want %0d", i, winner, m_win); end
      if (ball_run !== (m_phase == P_RALLY) ||
          ball_reset !== (m_phase == P_IDLE || m_phase == P_SERVE || m_phase == P_GO)) begin
        n_fail++; $display("FAIL rnd_ball[%0d]: run=%b reset=%b phase=%0d", i, ball_run, ball_reset, m_phase);
      end
      if (an !== exp_an()) begin n_fail++; $display("FAIL rnd_an[%0d]: got %b want %b", i, an, exp_an()); end
      if (digit_code !== exp_digit()) begin
        n_fail++; $display("FAIL rnd_digit[%0d]: got %h want %h", i, digit_code, exp_digit());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_serve();
    test_scoring();
    test_simultaneous();
    test_win();
    test_scan();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
